// File: rtl/eq_ctrl.sv
// Push-button tone control: debounces three raw keys and applies bass/treble/bypass changes
// only at a stereo frame boundary so a left/right pair never straddles two settings.
module eq_ctrl #(
    parameter int unsigned DEB_CYCLES = 60000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lrc_i,
    input  logic       data_valid_i,
    input  logic       key_bass_n_i,
    input  logic       key_treble_n_i,
    input  logic       key_bypass_n_i,
    output logic       sw_bass_up_o,
    output logic       sw_bass_down_o,
    output logic       sw_treble_up_o,
    output logic       sw_treble_down_o,
    output logic [1:0] bass_level_o,
    output logic [1:0] treble_level_o,
    output logic       bypass_o,
    output logic       pending_o
);

    localparam logic [1:0] LvlFlat  = 2'b00;
    localparam logic [1:0] LvlBoost = 2'b01;
    localparam logic [1:0] LvlCut   = 2'b10;
    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StApply} state_e;

    // Key index: 0 = bass, 1 = treble, 2 = bypass.
    logic [2:0]            keys_n;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            stable_q, stable_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            press;

    assign keys_n = {key_bypass_n_i, key_treble_n_i, key_bass_n_i};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press    = '0;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == DebLast) begin
                    stable_d[k] = sync2_q[k];
                    // Only the 1->0 transition is a press; releases are silent.
                    press[k]    = stable_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= keys_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    function automatic logic [1:0] next_level(input logic [1:0] lvl);
        case (lvl)
            LvlFlat:  return LvlBoost;
            LvlBoost: return LvlCut;
            default:  return LvlFlat;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [1:0] bass_q, bass_d, treble_q, treble_d;
    logic       bypass_q, bypass_d;
    logic [1:0] pend_bass_q, pend_bass_d, pend_treble_q, pend_treble_d;
    logic       pend_bypass_q, pend_bypass_d;
    logic [1:0] base_bass, base_treble;
    logic       base_bypass;
    logic       sw_bass_up_q, sw_bass_down_q, sw_treble_up_q, sw_treble_down_q;

    always_comb begin
        state_d     = state_q;
        bass_d      = bass_q;
        treble_d    = treble_q;
        bypass_d    = bypass_q;
        base_bass   = pend_bass_q;
        base_treble = pend_treble_q;
        base_bypass = pend_bypass_q;
        unique case (state_q)
            StIdle: begin
                base_bass   = bass_q;
                base_treble = treble_q;
                base_bypass = bypass_q;
                if (|press) state_d = StWait;
            end
            StWait: begin
                if (data_valid_i && !lrc_i) state_d = StApply;
            end
            StApply: begin
                // Pending values become the applied ones; a press now builds on them.
                bass_d   = pend_bass_q;
                treble_d = pend_treble_q;
                bypass_d = pend_bypass_q;
                state_d  = (|press) ? StWait : StIdle;
            end
            default: state_d = StIdle;
        endcase
        pend_bass_d   = press[0] ? next_level(base_bass) : base_bass;
        pend_treble_d = press[1] ? next_level(base_treble) : base_treble;
        pend_bypass_d = base_bypass ^ press[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            bass_q           <= LvlFlat;
            treble_q         <= LvlFlat;
            bypass_q         <= 1'b0;
            pend_bass_q      <= LvlFlat;
            pend_treble_q    <= LvlFlat;
            pend_bypass_q    <= 1'b0;
            sw_bass_up_q     <= 1'b0;
            sw_bass_down_q   <= 1'b0;
            sw_treble_up_q   <= 1'b0;
            sw_treble_down_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            bass_q           <= bass_d;
            treble_q         <= treble_d;
            bypass_q         <= bypass_d;
            pend_bass_q      <= pend_bass_d;
            pend_treble_q    <= pend_treble_d;
            pend_bypass_q    <= pend_bypass_d;
            sw_bass_up_q     <= (bass_d == LvlBoost) && !bypass_d;
            sw_bass_down_q   <= (bass_d == LvlCut) && !bypass_d;
            sw_treble_up_q   <= (treble_d == LvlBoost) && !bypass_d;
            sw_treble_down_q <= (treble_d == LvlCut) && !bypass_d;
        end
    end

    assign sw_bass_up_o     = sw_bass_up_q;
    assign sw_bass_down_o   = sw_bass_down_q;
    assign sw_treble_up_o   = sw_treble_up_q;
    assign sw_treble_down_o = sw_treble_down_q;
    assign bass_level_o     = bass_q;
    assign treble_level_o   = treble_q;
    assign bypass_o         = bypass_q;
    assign pending_o        = (state_q == StWait);

endmodule

// File: tb/tb_eq_ctrl.sv
// Directed bench for eq_ctrl with a short debounce window; expected values are hand-derived.
module tb_eq_ctrl;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lrc = 1'b1;
    logic       dv = 1'b0;
    logic       kb_n = 1'b1, kt_n = 1'b1, ky_n = 1'b1;
    logic       sbu, sbd, stu, std;
    logic [1:0] bass_lvl, treble_lvl;
    logic       byp, pend;

    int checks = 0;
    int failures = 0;

    eq_ctrl #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lrc_i            (lrc),
        .data_valid_i     (dv),
        .key_bass_n_i     (kb_n),
        .key_treble_n_i   (kt_n),
        .key_bypass_n_i   (ky_n),
        .sw_bass_up_o     (sbu),
        .sw_bass_down_o   (sbd),
        .sw_treble_up_o   (stu),
        .sw_treble_down_o (std),
        .bass_level_o     (bass_lvl),
        .treble_level_o   (treble_lvl),
        .bypass_o         (byp),
        .pending_o        (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        kb_n = 1'b1; kt_n = 1'b1; ky_n = 1'b1; dv = 1'b0; lrc = 1'b1;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Key index: 0 bass, 1 treble, 2 bypass. Holds long enough to debounce both edges.
    task automatic press(input int k);
        if (k == 0) kb_n = 1'b0; else if (k == 1) kt_n = 1'b0; else ky_n = 1'b0;
        cyc(10);
        kb_n = 1'b1; kt_n = 1'b1; ky_n = 1'b1;
        cyc(8);
    endtask

    // One-cycle strobe, then run through APPLY so the applied outputs are visible.
    task automatic strobe(input logic l);
        lrc = l; dv = 1'b1;
        cyc(1);
        dv = 1'b0; lrc = 1'b1;
        cyc(1);
    endtask

    initial begin
        cyc(1);
        check("rst_pending", {7'd0, pend}, 8'd0);
        check("rst_bass", {6'd0, bass_lvl}, 8'd0);
        rst_n = 1'b1;
        cyc(1);
        check("rst_sw", {4'd0, sbu, sbd, stu, std}, 8'd0);
        check("rst_treble", {6'd0, treble_lvl}, 8'd0);
        check("rst_bypass", {7'd0, byp}, 8'd0);

        // Single bass press; left strobe ignored, right strobe applies.
        press(0);
        check("b1_pending", {7'd0, pend}, 8'd1);
        strobe(1'b1);
        check("b1_lrc1_pending", {7'd0, pend}, 8'd1);
        check("b1_lrc1_bass", {6'd0, bass_lvl}, 8'd0);
        strobe(1'b0);
        check("b1_bass", {6'd0, bass_lvl}, 8'd1);
        check("b1_sw", {4'd0, sbu, sbd, stu, std}, 8'b1000);
        check("b1_pending_clr", {7'd0, pend}, 8'd0);

        // Three presses wrap back to FLAT.
        do_reset();
        press(0); press(0); press(0);
        check("b3_pending", {7'd0, pend}, 8'd1);
        strobe(1'b0);
        check("b3_bass", {6'd0, bass_lvl}, 8'd0);
        check("b3_sw", {4'd0, sbu, sbd, stu, std}, 8'd0);
        check("b3_pending_clr", {7'd0, pend}, 8'd0);

        // Glitch of 3 cycles is rejected; a clean press is taken once.
        do_reset();
        kt_n = 1'b0;
        cyc(3);
        kt_n = 1'b1;
        cyc(10);
        check("glitch_pending", {7'd0, pend}, 8'd0);
        press(1);
        check("t1_pending", {7'd0, pend}, 8'd1);
        strobe(1'b0);
        check("t1_treble", {6'd0, treble_lvl}, 8'd1);
        check("t1_sw", {4'd0, sbu, sbd, stu, std}, 8'b0010);

        // Bypass masks the switch outputs but keeps the level.
        do_reset();
        press(0); strobe(1'b0);
        press(2); strobe(1'b0);
        check("byp_on", {7'd0, byp}, 8'd1);
        check("byp_on_sw", {4'd0, sbu, sbd, stu, std}, 8'd0);
        check("byp_on_bass", {6'd0, bass_lvl}, 8'd1);
        press(2); strobe(1'b0);
        check("byp_off", {7'd0, byp}, 8'd0);
        check("byp_off_sw", {4'd0, sbu, sbd, stu, std}, 8'b1000);

        // Simultaneous presses both captured.
        do_reset();
        kb_n = 1'b0; kt_n = 1'b0;
        cyc(10);
        kb_n = 1'b1; kt_n = 1'b1;
        cyc(8);
        strobe(1'b0);
        check("sim_bass", {6'd0, bass_lvl}, 8'd1);
        check("sim_treble", {6'd0, treble_lvl}, 8'd1);

        // Bass -> CUT pending; a treble press lands exactly in the APPLY cycle.
        press(0);
        kt_n = 1'b0;
        cyc(4);
        lrc = 1'b0; dv = 1'b1;
        cyc(1);
        check("apl_state_apply", {7'd0, pend}, 8'd0);
        dv = 1'b0; lrc = 1'b1;
        cyc(1);
        check("apl_pending", {7'd0, pend}, 8'd1);
        check("apl_bass", {6'd0, bass_lvl}, 8'd2);
        check("apl_treble_old", {6'd0, treble_lvl}, 8'd1);
        check("apl_sw", {4'd0, sbu, sbd, stu, std}, 8'b0110);
        kt_n = 1'b1;
        cyc(8);
        strobe(1'b0);
        check("apl_treble_new", {6'd0, treble_lvl}, 8'd2);
        check("apl_sw2", {4'd0, sbu, sbd, stu, std}, 8'b0101);

        // Reset in WAIT discards the pending change.
        do_reset();
        press(0);
        check("rw_pending", {7'd0, pend}, 8'd1);
        rst_n = 1'b0;
        #2;
        check("rw_in_rst_pending", {7'd0, pend}, 8'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        strobe(1'b0);
        cyc(1);
        check("rw_bass", {6'd0, bass_lvl}, 8'd0);
        check("rw_pending_after", {7'd0, pend}, 8'd0);

        // Key held across reset release: one event after DEB+2 edges.
        kb_n = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(DEB + 1);
        check("hold_early", {7'd0, pend}, 8'd0);
        cyc(1);
        check("hold_event", {7'd0, pend}, 8'd1);
        cyc(20);
        kb_n = 1'b1;
        cyc(8);
        strobe(1'b0);
        check("hold_once", {6'd0, bass_lvl}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
